// File: rtl/usbf_pkg.sv
// usbf_pkg: shared PID nibbles, token decoder state type and CRC5 seed
package usbf_pkg;
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [4:0] CRC5_INIT = 5'h1f;
  typedef enum logic [2:0] {IDLE, FIELD1, FIELD2, CHECK, DRAIN} state_t;
endpackage

// File: rtl/usbf_crc5.sv
// usbf_crc5: 11-bit parallel USB CRC5 (x^5+x^2+1), din[10] is the first bit on the wire
// Ports: crc_in seed, din 11-bit data, crc_out raw generator state (not inverted).
module usbf_crc5 (
  input  logic [4:0]  crc_in,
  input  logic [10:0] din,
  output logic [4:0]  crc_out
);
  logic [4:0] c;
  always_comb begin
    c = crc_in;
    for (int i = 10; i >= 0; i--)
      c = {c[3:0], 1'b0} ^ ((din[i] ^ c[4]) ? 5'b00101 : 5'b00000);
    crc_out = c;
  end
endmodule

// File: rtl/usbf_token_dec.sv
// usbf_token_dec: UTMI receive-side decoder for OUT/IN/SETUP (and optionally SOF) tokens
// Ports: clk/rst (async, active-high); rx_data/rx_valid/rx_active/rx_err from UTMI;
// token_valid/sof_valid/crc5_err/pid_err one-cycle strobes; token_pid/fa/ep and frame_no latched.
// Define USBF_SOF_DEC_EN to decode SOF; otherwise SOF is drained and sof_valid/frame_no are 0.
module usbf_token_dec
  import usbf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_err,
  output logic        token_valid,
  output logic [3:0]  token_pid,
  output logic [6:0]  token_fa,
  output logic [3:0]  token_ep,
  output logic        sof_valid,
  output logic [10:0] frame_no,
  output logic        crc5_err,
  output logic        pid_err
);
  state_t state, state_n;
  logic [3:0] pid;
  logic [7:0] b1, b2;
  logic [10:0] f, din;
  logic [4:0] crc, crc_exp;
  logic tv_n, ce_n, pe_n, cap_pid, cap_b1, cap_b2, is_tok, is_sof;
`ifdef USBF_SOF_DEC_EN
  logic sv_n;
  assign is_sof = rx_data[3:0] == PID_SOF;
`else
  assign is_sof = 1'b0;
`endif
  assign f = {b2[2:0], b1};
  assign is_tok = rx_data[3:0] inside {PID_OUT, PID_IN, PID_SETUP};
  always_comb begin
    din = '0;
    for (int i = 0; i < 11; i++) din[10-i] = f[i];
  end
  usbf_crc5 u_crc5 (.crc_in(CRC5_INIT), .din(din), .crc_out(crc));
  // received CRC field is the inverted generator state, sent LSB-first
  always_comb begin
    crc_exp = '0;
    for (int i = 0; i < 5; i++) crc_exp[i] = ~crc[4-i];
  end
  always_comb begin
    state_n = state;
    tv_n    = 1'b0;
    ce_n    = 1'b0;
    pe_n    = 1'b0;
    cap_pid = 1'b0;
    cap_b1  = 1'b0;
    cap_b2  = 1'b0;
`ifdef USBF_SOF_DEC_EN
    sv_n    = 1'b0;
`endif
    if (rx_err) state_n = rx_active ? DRAIN : IDLE;
    else
      case (state)
        IDLE:
          if (rx_valid && rx_active) begin
            cap_pid = 1'b1;
            pe_n    = rx_data[7:4] != ~rx_data[3:0];
            state_n = (!pe_n && (is_tok || is_sof)) ? FIELD1 : DRAIN;
          end
        FIELD1: begin
          cap_b1  = rx_valid;
          state_n = !rx_active ? IDLE : rx_valid ? FIELD2 : FIELD1;
        end
        // a byte arriving with the end of packet is still taken; CHECK then sees the end
        FIELD2: begin
          cap_b2  = rx_valid;
          state_n = rx_valid ? CHECK : rx_active ? FIELD2 : IDLE;
        end
        CHECK:
          if (rx_valid) state_n = rx_active ? DRAIN : IDLE;
          else if (!rx_active) begin
            state_n = IDLE;
            ce_n    = crc_exp != b2[7:3];
`ifdef USBF_SOF_DEC_EN
            sv_n    = !ce_n && pid == PID_SOF;
            tv_n    = !ce_n && pid != PID_SOF;
`else
            tv_n    = !ce_n;
`endif
          end
        DRAIN: state_n = rx_active ? DRAIN : IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      pid         <= '0;
      b1          <= '0;
      b2          <= '0;
      token_valid <= 1'b0;
      crc5_err    <= 1'b0;
      pid_err     <= 1'b0;
      token_pid   <= '0;
      token_fa    <= '0;
      token_ep    <= '0;
    end else begin
      state       <= state_n;
      token_valid <= tv_n;
      crc5_err    <= ce_n;
      pid_err     <= pe_n;
      if (cap_pid) pid <= rx_data[3:0];
      if (cap_b1) b1 <= rx_data;
      if (cap_b2) b2 <= rx_data;
      if (tv_n) begin
        token_pid <= pid;
        token_fa  <= f[6:0];
        token_ep  <= f[10:7];
      end
`ifdef USBF_SOF_DEC_EN
      if (sv_n) token_pid <= pid;
`endif
    end
`ifdef USBF_SOF_DEC_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sof_valid <= 1'b0;
      frame_no  <= '0;
    end else begin
      sof_valid <= sv_n;
      if (sv_n) frame_no <= f;
    end
`else
  assign sof_valid = 1'b0;
  assign frame_no  = '0;
`endif
endmodule

// File: tb/tb_usbf_token_dec.sv
// tb_usbf_token_dec: table-driven scoreboard bench for usbf_token_dec
module tb_usbf_token_dec;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_active = 1'b0, rx_err = 1'b0;
  logic token_valid, sof_valid, crc5_err, pid_err;
  logic [3:0] token_pid, token_ep;
  logic [6:0] token_fa;
  logic [10:0] frame_no;
  usbf_token_dec dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_err(rx_err), .token_valid(token_valid), .token_pid(token_pid), .token_fa(token_fa),
    .token_ep(token_ep), .sof_valid(sof_valid), .frame_no(frame_no), .crc5_err(crc5_err),
    .pid_err(pid_err)
  );
  always #5 clk = ~clk;
  // kind: 0 none, 1 token, 2 sof, 3 crc5_err, 4 pid_err
  typedef struct {
    logic [3:0][7:0] b;
    int n;
    bit eop_last;
    int err_at;
    int kind;
    logic [3:0] pid;
    logic [10:0] f;
  } vec_t;
`ifdef USBF_SOF_DEC_EN
  localparam int SOF_K = 2, SOF_BAD = 3;
`else
  localparam int SOF_K = 0, SOF_BAD = 0;
`endif
  int checks = 0, errors = 0;
  int got_kind, nstrobe;
  vec_t tbl[$];
  vec_t q[$];
  logic [3:0] m_pid = '0, m_ep = '0;
  logic [6:0] m_fa = '0;
  logic [10:0] m_frame = '0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // reflected (LSB-first) CRC5, returns the on-wire field value byte2[7:3]
  function automatic logic [4:0] crc_ref(input logic [10:0] f);
    logic [4:0] c;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction
  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int n, input bit eop,
                              input int err, input int kind, input logic [3:0] pid,
                              input logic [10:0] f);
    vec_t v;
    v.b = {b3, b2, b1, b0};
    v.n = n;
    v.eop_last = eop;
    v.err_at = err;
    v.kind = kind;
    v.pid = pid;
    v.f = f;
    return v;
  endfunction
  function automatic vec_t good(input logic [3:0] p, input logic [10:0] f, input bit bad,
                                input int kind);
    logic [4:0] c;
    c = crc_ref(f) ^ (bad ? 5'h04 : 5'h00);
    return mk({~p, p}, f[7:0], {c, f[10:8]}, 8'h00, 3, 1'b0, -1, kind, p, f);
  endfunction
  always @(negedge clk) begin
    nstrobe += int'(token_valid) + int'(sof_valid) + int'(crc5_err) + int'(pid_err);
    if (token_valid) got_kind = 1;
    if (sof_valid) got_kind = 2;
    if (crc5_err) got_kind = 3;
    if (pid_err) got_kind = 4;
  end
  task automatic send(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      rx_data = v.b[i];
      rx_valid = 1'b1;
      rx_active = !(v.eop_last && i == v.n - 1);
      rx_err = (i == v.err_at);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_active = 1'b0;
    rx_err = 1'b0;
  endtask
  task automatic check_fields(input string tag);
    chk({tag, ".token_pid"}, int'(token_pid), int'(m_pid));
    chk({tag, ".token_fa"}, int'(token_fa), int'(m_fa));
    chk({tag, ".token_ep"}, int'(token_ep), int'(m_ep));
    chk({tag, ".frame_no"}, int'(frame_no), int'(m_frame));
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    got_kind = 0;
    nstrobe = 0;
    q.push_back(v);
    send(v);
    repeat (4) @(negedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".kind"}, got_kind, e.kind);
    chk({tag, ".nstrobe"}, nstrobe, (e.kind != 0) ? 1 : 0);
    if (e.kind == 1) begin
      m_pid = e.pid;
      m_fa = e.f[6:0];
      m_ep = e.f[10:7];
    end
    if (e.kind == 2) begin
      m_pid = e.pid;
      m_frame = e.f;
    end
    check_fields(tag);
  endtask
  initial begin
    logic [3:0] p;
    logic [10:0] f;
    bit bad;
    tbl.push_back(mk(8'h2D, 8'h00, 8'h10, 8'h00, 3, 1'b0, -1, 1, 4'hD, 11'h000));
    tbl.push_back(mk(8'h69, 8'h00, 8'h11, 8'h00, 3, 1'b0, -1, 3, 4'h9, 11'h100));
    tbl.push_back(mk(8'h2C, 8'h00, 8'h10, 8'h00, 3, 1'b0, -1, 4, 4'hC, 11'h000));
    tbl.push_back(mk(8'h2D, 8'h00, 8'h00, 8'h00, 2, 1'b0, -1, 0, 4'hD, 11'h000));
    tbl.push_back(mk(8'h2D, 8'h00, 8'h10, 8'h00, 4, 1'b0, -1, 0, 4'hD, 11'h000));
    tbl.push_back(mk(8'h2D, 8'h00, 8'h10, 8'h00, 3, 1'b0, -1, 1, 4'hD, 11'h000));
    tbl.push_back(mk(8'h2D, 8'h00, 8'h10, 8'h00, 3, 1'b0, 1, 0, 4'hD, 11'h000));
    tbl.push_back(good(4'h1, 11'h3A5, 1'b0, 1));
    tbl.push_back(good(4'h9, 11'h7FF, 1'b0, 1));
    begin
      vec_t v;
      v = good(4'hD, 11'h0C3, 1'b0, 1);
      v.eop_last = 1'b1;
      tbl.push_back(v);
    end
    tbl.push_back(mk(8'hA5, 8'h01, 8'hE8, 8'h00, 3, 1'b0, -1, SOF_K, 4'h5, 11'h001));
    tbl.push_back(mk(8'hD2, 8'h00, 8'h10, 8'h00, 3, 1'b0, -1, 0, 4'h2, 11'h000));
    tbl.push_back(mk(8'hA5, 8'h01, 8'hE0, 8'h00, 3, 1'b0, -1, SOF_BAD, 4'h5, 11'h001));
    tbl.push_back(good(4'h5, 11'h7A3, 1'b0, SOF_K));
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0: p = 4'h1;
        1: p = 4'h9;
        default: p = 4'hD;
      endcase
      f = 11'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      tbl.push_back(good(p, f, bad, bad ? 3 : 1));
    end
    repeat (2) @(negedge clk);
    chk("rst.token_valid", int'(token_valid), 0);
    chk("rst.sof_valid", int'(sof_valid), 0);
    chk("rst.crc5_err", int'(crc5_err), 0);
    chk("rst.pid_err", int'(pid_err), 0);
    check_fields("rst");
    rst = 1'b0;
    foreach (tbl[i]) run_vec(tbl[i], i);
    // pid_err latency: strobe visible the cycle after the PID byte, one cycle wide
    got_kind = 0;
    nstrobe = 0;
    @(negedge clk);
    rx_data = 8'h2C; rx_valid = 1'b1; rx_active = 1'b1;
    @(negedge clk);
    rx_data = 8'h00;
    chk("pid_lat.hi", int'(pid_err), 1);
    @(negedge clk);
    rx_data = 8'h10;
    chk("pid_lat.lo", int'(pid_err), 0);
    @(negedge clk);
    rx_valid = 1'b0; rx_active = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pid_lat.nstrobe", nstrobe, 1);
    // token strobe timing and a new packet starting in the strobe cycle
    f = 11'h155;
    @(negedge clk); rx_data = 8'h2D; rx_valid = 1'b1; rx_active = 1'b1;
    @(negedge clk); rx_data = 8'h00;
    @(negedge clk); rx_data = 8'h10;
    @(negedge clk); rx_valid = 1'b0; rx_active = 1'b0;
    @(negedge clk);
    chk("b2b.tv1", int'(token_valid), 1);
    rx_data = 8'hE1; rx_valid = 1'b1; rx_active = 1'b1;
    @(negedge clk);
    chk("b2b.tv1_off", int'(token_valid), 0);
    rx_data = f[7:0];
    @(negedge clk); rx_data = {crc_ref(f), f[10:8]};
    @(negedge clk); rx_valid = 1'b0; rx_active = 1'b0;
    @(negedge clk);
    chk("b2b.tv2", int'(token_valid), 1);
    m_pid = 4'h1; m_fa = f[6:0]; m_ep = f[10:7];
    check_fields("b2b");
    // reset in the middle of a packet clears everything at once
    @(negedge clk); rx_data = 8'h2D; rx_valid = 1'b1; rx_active = 1'b1;
    @(negedge clk); rx_data = 8'h00;
    @(negedge clk); rx_valid = 1'b0; rx_active = 1'b0; rst = 1'b1;
    #1;
    m_pid = '0; m_fa = '0; m_ep = '0; m_frame = '0;
    chk("midrst.token_valid", int'(token_valid), 0);
    check_fields("midrst");
    @(negedge clk); rst = 1'b0;
    run_vec(good(4'h9, 11'h2B6, 1'b0, 1), 100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
